// File: rtl/timer_bank.sv
// Multi-channel programmable interval timer: shared prescaler, per-channel reload/one-shot
// counters, expiry status, combined active-low interrupt and tear-free multi-byte COUNT reads.
module timer_bank #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16,
  parameter int PRESCALE = 24000,
  parameter int PS_WIDTH = 15
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cs,
  input  logic                          wr,
  input  logic                          rd,
  input  logic [$clog2(CHANNELS)+3:0]   addr,
  input  logic [7:0]                    din,
  output logic [7:0]                    dout,
  output logic                          irq_n,
  output logic [CHANNELS-1:0]           expired
);

  localparam int AW = $clog2(CHANNELS) + 4;
  localparam int NB = WIDTH / 8;

  logic [PS_WIDTH-1:0] ps;
  logic                tick;

  logic [3:0]    off;
  logic [AW-1:0] ch_full;

  logic [CHANNELS-1:0][WIDTH-1:0] count;
  logic [CHANNELS-1:0][WIDTH-1:0] reload;
  logic [CHANNELS-1:0][WIDTH-1:0] snap;
  logic [CHANNELS-1:0]            en;
  logic [CHANNELS-1:0]            auto_rl;
  logic [CHANNELS-1:0]            irq_en;
  logic [CHANNELS-1:0]            status;

  logic [CHANNELS-1:0]            sel;
  logic [CHANNELS-1:0]            ctrl_wr;
  logic [CHANNELS-1:0]            rl_wr;
  logic [CHANNELS-1:0]            st_clr;
  logic [CHANNELS-1:0]            snap_ld;
  logic [CHANNELS-1:0]            load;
  logic [CHANNELS-1:0]            run;
  logic [CHANNELS-1:0]            expire;
  logic [CHANNELS-1:0]            auto_eff;
  logic [CHANNELS-1:0][WIDTH-1:0] rl_new;

  assign off     = addr[3:0];
  assign ch_full = addr >> 4;
  assign tick    = (ps == PS_WIDTH'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (reset || tick) ps <= '0;
    else               ps <= ps + PS_WIDTH'(1);
  end

  // A CTRL write in the tick cycle takes priority: 0->1 loads, enable=0 suppresses the tick.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      sel[c]      = (ch_full == AW'(c));
      ctrl_wr[c]  = cs & wr & sel[c] & (off == 4'h8);
      rl_wr[c]    = cs & wr & sel[c] & (off[3:2] == 2'b01);
      st_clr[c]   = cs & wr & sel[c] & (off == 4'h9) & din[0];
      snap_ld[c]  = cs & rd & sel[c] & (off == 4'h0);
      load[c]     = ctrl_wr[c] & din[0] & ~en[c];
      run[c]      = tick & en[c] & (~ctrl_wr[c] | din[0]);
      expire[c]   = run[c] & (count[c] == '0);
      auto_eff[c] = ctrl_wr[c] ? din[1] : auto_rl[c];
      for (int b = 0; b < NB; b++) begin
        rl_new[c][8*b +: 8] = (off[1:0] == 2'(b)) ? din : reload[c][8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      reload  <= '0;
      snap    <= '0;
      en      <= '0;
      auto_rl <= '0;
      irq_en  <= '0;
      status  <= '0;
      expired <= '0;
      irq_n   <= 1'b1;
    end else begin
      expired <= expire;
      irq_n   <= ~|(status & irq_en);
      for (int c = 0; c < CHANNELS; c++) begin
        if (snap_ld[c]) snap[c] <= count[c];
        if (rl_wr[c])   reload[c] <= rl_new[c];
        if (ctrl_wr[c]) begin
          en[c]      <= din[0];
          auto_rl[c] <= din[1];
          irq_en[c]  <= din[2];
        end
        // Expiry uses the pre-write RELOAD; a one-shot expiry overrides any enable rewrite.
        if (load[c]) begin
          count[c] <= reload[c];
        end else if (run[c]) begin
          if (expire[c]) begin
            if (auto_eff[c]) count[c] <= reload[c];
            else             en[c]    <= 1'b0;
          end else begin
            count[c] <= count[c] - WIDTH'(1);
          end
        end
        if (st_clr[c]) status[c] <= 1'b0;
        if (expire[c]) status[c] <= 1'b1;
      end
    end
  end

  // Byte 0 of COUNT is live; bytes 1..3 come from the snapshot taken when byte 0 was read.
  always_comb begin
    dout = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (sel[c]) begin
        case (off)
          4'h0, 4'h1, 4'h2, 4'h3: begin
            for (int b = 0; b < NB; b++) begin
              if (off[1:0] == 2'(b)) dout = (b == 0) ? count[c][7:0] : snap[c][8*b +: 8];
            end
          end
          4'h4, 4'h5, 4'h6, 4'h7: begin
            for (int b = 0; b < NB; b++) begin
              if (off[1:0] == 2'(b)) dout = reload[c][8*b +: 8];
            end
          end
          4'h8:    dout = {5'b0, irq_en[c], auto_rl[c], en[c]};
          4'h9:    dout = {7'b0, status[c]};
          default: dout = '0;
        endcase
      end
    end
  end

endmodule

// File: doc/timer_bank.md
# timer_bank

Parametrised multi-channel programmable interval timer for the Aznable system. It is the successor to the single free-running millisecond timer and sits on the CPU memory-mapped bus. Each channel has a reload value, one-shot or auto-reload mode, an expiry status flag and an interrupt enable; all channels share one prescaler. Expiries raise a combined active-low interrupt for the Z80 `int_n`, and a snapshot latch makes multi-byte counter reads tear-free.

## Interface
Parameters:
- `CHANNELS`, 4: number of timer channels, 1..16.
- `WIDTH`, 16: counter and reload width in bits; one of 8, 16, 24 or 32.
- `PRESCALE`, 24000: `clk` cycles per tick (24000 gives 1 ms at 24 MHz); minimum 1.
- `PS_WIDTH`, 15: prescaler counter width; must hold `PRESCALE-1`.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `cs` in 1: block select, decoded by the system.
- `wr` in 1: write strobe, active high, level-sensitive.
- `rd` in 1: read strobe, active high.
- `addr` in `$clog2(CHANNELS)+4`: register address. The upper bits select the channel; the low 4 bits select the register.
- `din` in 8: CPU write data.
- `dout` out 8: read data, combinational from `addr` and state.
- `irq_n` out 1: registered OR of (status & irq_en) across channels, inverted.
- `expired` out `CHANNELS`: one-cycle pulse per channel on each expiry.

## Operation
Per-channel register map (offset within a 16-byte channel slot):
- 0x0..0x3 `COUNT` bytes, little-endian, read-only.
  - Reading byte 0 copies bytes 1..3 into the snapshot latch.
  - Reads of bytes 1..3 return the latch, not the live counter.
- 0x4..0x7 `RELOAD` bytes, read/write.
- 0x8 `CTRL`, read/write:
  - bit0 = enable
  - bit1 = auto-reload
  - bit2 = irq_en
  - bits 7:3 read 0.
- 0x9 `STATUS`: bit0 = expired. Writing 1 to bit0 clears it; writing 0 has no effect.
- All other offsets read 0x00 and ignore writes.
- Bytes at or above `WIDTH/8` in `COUNT` and `RELOAD` read 0 and ignore writes.

Writes:
- A write happens on every cycle with `cs & wr`. Writes are idempotent, so a multi-cycle `wr` is harmless.
- `CTRL` enable going 0→1 loads `COUNT` ← `RELOAD`. Rewriting enable=1 while it is already 1 does not reload.
- Writing `RELOAD` never changes a running `COUNT`; the new value takes effect at the next reload.

Prescaler:
- Free-running from 0 to `PRESCALE-1`.
- Emits an internal `tick` for one cycle when it wraps.
- It is not affected by channel enables.

Channel update on `tick` with enable=1:
- If `COUNT` ≠ 0: `COUNT` ← `COUNT` − 1.
- If `COUNT` = 0, expiry occurs:
  - `STATUS` ← 1 and `expired[ch]` pulses.
  - If auto-reload: `COUNT` ← `RELOAD`.
  - Otherwise enable ← 0 and `COUNT` stays 0.
- The period is `RELOAD+1` ticks. `RELOAD` = 0 with auto-reload expires on every tick.

A disabled channel holds `COUNT`.

## Timing
- Reset values:
  - `COUNT`, `RELOAD`, `CTRL`, `STATUS`, the snapshot latch and the prescaler are all 0.
  - `irq_n` = 1 and `expired` = 0.
  - Reset asserted mid-count aborts immediately; no expiry pulse is produced in the reset cycle.
- `dout` is combinational with zero latency. The T80 data mux samples it directly.
- State updates occur on the `clk` edge that ends the access cycle.
- `expired[ch]` is high in the cycle after the `tick` cycle. `STATUS` reads 1 from that cycle onward.
- `irq_n` falls one cycle after `STATUS` & irq_en becomes true. It rises one cycle after the last qualifying status is cleared or irq_en is cleared.
- Simultaneous events in one cycle:
  - A `STATUS` clear and an expiry: set wins, and `STATUS` stays 1.
  - A `CTRL` enable 0→1 and a `tick`: the load wins, and no decrement occurs that tick.
  - A `CTRL` write of enable=0 and a `tick`: the disable wins, and there is no decrement and no expiry.
  - A `RELOAD` write and an auto-reload: the reload uses the old `RELOAD` value.
- The snapshot latch updates on every cycle with `cs & rd` at offset 0. It holds the value from the last cycle of the read.
- `COUNT` wraps from 0 only through expiry. There is no underflow past 0.

## Test plan
- **Reset:** after reset, read every address of channels 0..3 → all 0x00, `irq_n` = 1, `expired` = 0.
- **Auto-reload:** `PRESCALE`=4, ch0 `RELOAD`=3, `CTRL`=0x03 → `COUNT` reads 3,2,1,0,3 at 4-clock spacing. `expired[0]` pulses every 16 clocks. `STATUS`=1 and `irq_n` stays 1 because irq_en = 0.
- **One-shot with interrupt:** ch1 `RELOAD`=2, `CTRL`=0x05 → a single `expired[1]` pulse after 3 ticks, `CTRL` reads 0x04, `irq_n` falls 1 cycle later. Writing `STATUS`=0x01 raises `irq_n` 1 cycle later. `STATUS`=0x00 has no effect.
- **Clear/expiry collision:** a `STATUS` write of 0x01 coincides with an expiry → `STATUS` reads 1 and `irq_n` stays 0.
- **Tear-free read:** `WIDTH`=16, `COUNT`=0x0100. Read offset 0 → 0x00; a tick then decrements `COUNT` to 0x00FF; read offset 1 → 0x01 (latched). Re-reading offset 0 then offset 1 → 0xFF, 0x00.
- **Addressing and reset:** with `CHANNELS`=4, ch3 registers are at 0x30..0x39 and run independently of ch0. Offset 0xA returns 0. Asserting `reset` mid-count → all counters 0, `irq_n` = 1, and no `expired` pulse.
